vdp_host_port: RTL and testbench

CPU-facing write/read port of the VDP. It turns 8-bit CPU bus cycles on four port addresses into VRAM writes through a small write FIFO, VRAM reads through a one-byte prefetch buffer, and VDP register writes. It sits between the CPU bus and the VDP's shared VRAM port. The VDP display fetcher grants it VRAM slots through a request/grant handshake.

---
 rtl/vdp_host_port.sv | 136 +++++++++++++
 tb/tb_vdp_host_port.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_host_port.sv
// vdp_host_port: CPU port turning bus cycles into FIFO'd VRAM writes, prefetched VRAM reads and VDP register writes
// Ports: cpu* = 8-bit CPU bus (cpuWait, cpuDataOut combinational), vBlank = status flag source,
//        vram* = request/grant VRAM slot port (registered), reg* = registered one-cycle register write.
module vdp_host_port #(
  parameter int RamBits   = 16,
  parameter int FifoDepth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuCs,
  input  logic               cpuWr,
  input  logic               cpuRd,
  input  logic [1:0]         cpuPort,
  input  logic [7:0]         cpuDataIn,
  output logic [7:0]         cpuDataOut,
  output logic               cpuWait,
  input  logic               vBlank,
  output logic               vramReq,
  input  logic               vramGrant,
  output logic               vramWe,
  output logic [RamBits-1:0] vramAddr,
  output logic [7:0]         vramDataOut,
  input  logic [7:0]         vramDataIn,
  output logic               regWe,
  output logic [2:0]         regIndex,
  output logic [7:0]         regData
);
  localparam int PW = $clog2(FifoDepth);
  localparam int XW = RamBits + 16;
  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;
  state_t             state_q;
  logic [RamBits+7:0] fifo_q [FifoDepth];
  logic [PW-1:0]      wp_q, rp_q;
  logic [PW:0]        cnt_q;
  logic [RamBits-1:0] addr_q, addr_d;
  logic [7:0]         val_q, buf_q;
  logic               pair_q, vb_q, vbp_q, valid_q, pend_q, stale_q;
  logic               full, empty, acc, wr, rd, push, pop, inv, cap, p1w, p1r;
  // full/empty come from registered state only, so a same-cycle pop never lifts cpuWait
  assign full    = cnt_q == (PW+1)'(FifoDepth);
  assign empty   = cnt_q == '0;
  assign cpuWait = cpuCs && cpuPort == 2'd0 && ((cpuWr && full) || (cpuRd && !valid_q));
  assign acc     = cpuCs && (cpuWr || cpuRd) && !cpuWait;
  assign wr      = acc && cpuWr;
  assign rd      = acc && cpuRd;
  assign push    = wr && cpuPort == 2'd0;
  assign pop     = state_q == WR && vramGrant;
  assign p1w     = wr && cpuPort == 2'd1;
  assign p1r     = rd && cpuPort == 2'd1;
  // anything that moves A or consumes the buffer invalidates it and asks for a fresh prefetch
  assign inv     = (wr && cpuPort != 2'd1) || (rd && cpuPort == 2'd0);
  // a read that was overtaken by an address change is dropped instead of captured
  assign cap     = state_q == CAP && !stale_q && !inv;
  assign cpuDataOut = !rd ? 8'h00
                    : cpuPort == 2'd0 ? buf_q
                    : cpuPort == 2'd1 ? {vb_q, full, empty, valid_q, 4'b0}
                    : 8'h00;
  // address high byte bits above RamBits fall off through the final truncation
  assign addr_d = (acc && cpuPort == 2'd0) ? addr_q + 1'b1
                : (wr && cpuPort == 2'd2) ? RamBits'(({16'b0, addr_q} & ~XW'(16'h00FF)) | XW'(cpuDataIn))
                : (wr && cpuPort == 2'd3) ? RamBits'(({16'b0, addr_q} & ~XW'(16'hFF00)) | XW'({cpuDataIn, 8'h00}))
                : addr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      val_q       <= '0;
      buf_q       <= '0;
      pair_q      <= 1'b0;
      vb_q        <= 1'b0;
      vbp_q       <= 1'b0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b1;
      stale_q     <= 1'b0;
      vramReq     <= 1'b0;
      vramWe      <= 1'b0;
      vramAddr    <= '0;
      vramDataOut <= '0;
      regWe       <= 1'b0;
      regIndex    <= '0;
      regData     <= '0;
    end else begin
      addr_q <= addr_d;
      if (push) begin
        fifo_q[wp_q] <= {addr_q, cpuDataIn};
        wp_q         <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q  <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      vbp_q  <= vBlank;
      vb_q   <= (vBlank && !vbp_q) || (vb_q && !p1r);
      pair_q <= p1w ? !pair_q : p1r ? 1'b0 : pair_q;
      if (p1w && !pair_q) val_q <= cpuDataIn;
      regWe <= p1w && pair_q;
      if (p1w && pair_q) begin
        regIndex <= cpuDataIn[2:0];
        regData  <= val_q;
      end
      pend_q  <= inv || (pend_q && !cap);
      valid_q <= !inv && (valid_q || cap);
      if (cap) buf_q <= vramDataIn;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q                 <= WR;
            vramReq                 <= 1'b1;
            vramWe                  <= 1'b1;
            {vramAddr, vramDataOut} <= fifo_q[rp_q];
          end else if (pend_q) begin
            state_q  <= RD;
            vramReq  <= 1'b1;
            vramWe   <= 1'b0;
            vramAddr <= addr_q;
            stale_q  <= inv;
          end
        end
        WR: if (vramGrant) begin
          state_q <= IDLE;
          vramReq <= 1'b0;
          vramWe  <= 1'b0;
        end
        RD: begin
          stale_q <= stale_q || inv;
          if (vramGrant) begin
            state_q <= CAP;
            vramReq <= 1'b0;
          end
        end
        CAP: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdp_host_port.sv
// tb_vdp_host_port: directed table, hand corner-case sequences and randomized ops against a byte-array model
module tb_vdp_host_port;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cpuCs = 1'b0, cpuWr = 1'b0, cpuRd = 1'b0;
  logic [1:0]  cpuPort = 2'd0;
  logic [7:0]  cpuDataIn = 8'h00, cpuDataOut;
  logic        cpuWait, vBlank = 1'b0;
  logic        vramReq, vramGrant = 1'b0, vramWe;
  logic [15:0] vramAddr;
  logic [7:0]  vramDataOut, vramDataIn = 8'h00;
  logic        regWe;
  logic [2:0]  regIndex;
  logic [7:0]  regData;

  vdp_host_port dut (
    .clk(clk), .reset(reset), .cpuCs(cpuCs), .cpuWr(cpuWr), .cpuRd(cpuRd), .cpuPort(cpuPort),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuWait(cpuWait), .vBlank(vBlank),
    .vramReq(vramReq), .vramGrant(vramGrant), .vramWe(vramWe), .vramAddr(vramAddr),
    .vramDataOut(vramDataOut), .vramDataIn(vramDataIn), .regWe(regWe), .regIndex(regIndex),
    .regData(regData)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic gnt_en = 1'b1, gnt_rand = 1'b0;
  logic [7:0]  vmem    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'h0;
  logic [7:0]  ld_data = 8'h0;
  logic [23:0] wlog [$];

  always @(posedge clk) begin
    if (ld_en) vmem[ld_addr] <= ld_data;
    else if (vramReq && vramGrant) begin
      if (vramWe) begin
        vmem[vramAddr] <= vramDataOut;
        wlog.push_back({vramAddr, vramDataOut});
      end else vramDataIn <= vmem[vramAddr];
    end
  end

  always @(negedge clk) vramGrant = vramReq && gnt_en && (!gnt_rand || ($urandom % 2) == 0);

  initial begin
    #500000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic cpu_op(input logic [1:0] p, input logic w, input logic [7:0] d,
                        output logic [7:0] q, output int waits);
    @(negedge clk);
    cpuPort = p; cpuWr = w; cpuRd = !w; cpuDataIn = d; cpuCs = 1'b1;
    #1;
    waits = 0;
    while (cpuWait && waits < 400) begin
      @(negedge clk); #1;
      waits++;
    end
    chk("cpu_accept", 32'(cpuWait), 32'd0);
    q = cpuDataOut;
    @(posedge clk); #1;
    cpuCs = 1'b0; cpuWr = 1'b0; cpuRd = 1'b0;
  endtask

  task automatic drain;
    logic [7:0] q;
    int w, n;
    n = 0;
    do begin
      cpu_op(2'd1, 1'b0, 8'h00, q, w);
      n++;
    end while (!q[5] && n < 100);
    chk("drain_empty", 32'(q[5]), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  typedef struct {
    logic [1:0] port;
    logic       wr;
    logic [7:0] din;
    logic [7:0] exp_q;
    logic       exp_we;
    logic [2:0] exp_idx;
    logic [7:0] exp_val;
  } vec_t;
  vec_t vt [10];

  logic [23:0] exp_b [6];
  logic [7:0]  q, d, ref_v;
  logic [15:0] ref_a;
  logic        ref_p;
  int          w, n;
  logic [15:0] touched [$];

  initial begin
    vt[0] = '{2'd1, 1'b1, 8'h55, 8'h00, 1'b0, 3'd0, 8'h00};
    vt[1] = '{2'd1, 1'b1, 8'h03, 8'h00, 1'b1, 3'd3, 8'h55};
    vt[2] = '{2'd1, 1'b1, 8'h11, 8'h00, 1'b0, 3'd0, 8'h00};
    vt[3] = '{2'd1, 1'b0, 8'h00, 8'h30, 1'b0, 3'd0, 8'h00};
    vt[4] = '{2'd1, 1'b1, 8'h22, 8'h00, 1'b0, 3'd0, 8'h00};
    vt[5] = '{2'd1, 1'b1, 8'h05, 8'h00, 1'b1, 3'd5, 8'h22};
    vt[6] = '{2'd2, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00};
    vt[7] = '{2'd3, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00};
    vt[8] = '{2'd1, 1'b1, 8'hAA, 8'h00, 1'b0, 3'd0, 8'h00};
    vt[9] = '{2'd1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd7, 8'hAA};
    exp_b = '{24'h123401, 24'h123502, 24'h123603, 24'h123704, 24'h123805, 24'h123966};

    // reset values and first prefetch
    load(16'h0000, 8'hA5);
    load(16'h0001, 8'h5A);
    load(16'h0040, 8'h99);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vramReq", 32'(vramReq), 32'd0);
    chk("rst_vramWe", 32'(vramWe), 32'd0);
    chk("rst_vramAddr", 32'(vramAddr), 32'd0);
    chk("rst_vramDataOut", 32'(vramDataOut), 32'd0);
    chk("rst_regWe", 32'(regWe), 32'd0);
    chk("rst_regIndex", 32'(regIndex), 32'd0);
    chk("rst_regData", 32'(regData), 32'd0);
    chk("rst_cpuDataOut", 32'(cpuDataOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_op(2'd0, 1'b0, 8'h00, q, w);
    chk("first_read_data", 32'(q), 32'hA5);
    chk("first_read_within_4", 32'(w <= 3), 32'd1);
    cpu_op(2'd0, 1'b0, 8'h00, q, w);
    chk("second_read_data", 32'(q), 32'h5A);
    chk("refill_latency", 32'(w), 32'd3);

    // register pairing and status table
    drain;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      cpu_op(vt[i].port, vt[i].wr, vt[i].din, q, w);
      chk($sformatf("vec%0d_dout", i), 32'(q), 32'(vt[i].exp_q));
      chk($sformatf("vec%0d_regWe", i), 32'(regWe), 32'(vt[i].exp_we));
      if (vt[i].exp_we) begin
        chk($sformatf("vec%0d_regIndex", i), 32'(regIndex), 32'(vt[i].exp_idx));
        chk($sformatf("vec%0d_regData", i), 32'(regData), 32'(vt[i].exp_val));
      end
    end

    // FIFO fills with grants withheld, then drains in order
    gnt_en = 1'b0;
    wlog.delete();
    cpu_op(2'd2, 1'b1, 8'h34, q, w);
    cpu_op(2'd3, 1'b1, 8'h12, q, w);
    for (int i = 1; i <= 4; i++) begin
      cpu_op(2'd0, 1'b1, 8'(i), q, w);
      chk("fifo_fill_nowait", 32'(w), 32'd0);
    end
    @(negedge clk);
    cpuPort = 2'd0; cpuWr = 1'b1; cpuDataIn = 8'h05; cpuCs = 1'b1;
    #1;
    chk("fifo_full_wait", 32'(cpuWait), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("fifo_full_hold", 32'(cpuWait), 32'd1);
    gnt_en = 1'b1;
    n = 0;
    while (cpuWait && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("fifo_fifth_accepted", 32'(cpuWait), 32'd0);
    @(posedge clk); #1;
    cpuCs = 1'b0; cpuWr = 1'b0;
    cpu_op(2'd0, 1'b1, 8'h66, q, w);
    drain;
    chk("fifo_log_size", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) chk($sformatf("fifo_log%0d", i), 32'(wlog[i]), 32'(exp_b[i]));

    // read after write to the same address never sees the old data
    gnt_rand = 1'b1;
    cpu_op(2'd2, 1'b1, 8'h40, q, w);
    cpu_op(2'd3, 1'b1, 8'h00, q, w);
    cpu_op(2'd0, 1'b1, 8'h7E, q, w);
    cpu_op(2'd2, 1'b1, 8'h40, q, w);
    cpu_op(2'd0, 1'b0, 8'h00, q, w);
    chk("raw_read", 32'(q), 32'h7E);
    gnt_rand = 1'b0;
    drain;

    // vBlank flag
    @(negedge clk);
    vBlank = 1'b1;
    repeat (2) @(posedge clk);
    cpu_op(2'd1, 1'b0, 8'h00, q, w);
    chk("vb_set", 32'(q[7]), 32'd1);
    cpu_op(2'd1, 1'b0, 8'h00, q, w);
    chk("vb_cleared", 32'(q[7]), 32'd0);
    @(negedge clk);
    vBlank = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vBlank = 1'b1; cpuPort = 2'd1; cpuRd = 1'b1; cpuCs = 1'b1;
    #1;
    chk("vb_same_cycle_read", 32'(cpuDataOut[7]), 32'd0);
    @(posedge clk); #1;
    cpuCs = 1'b0; cpuRd = 1'b0;
    cpu_op(2'd1, 1'b0, 8'h00, q, w);
    chk("vb_set_wins", 32'(q[7]), 32'd1);
    vBlank = 1'b0;

    // address wrap and write-request latency
    wlog.delete();
    cpu_op(2'd3, 1'b1, 8'hFF, q, w);
    cpu_op(2'd2, 1'b1, 8'hFF, q, w);
    repeat (10) @(posedge clk);
    cpu_op(2'd0, 1'b1, 8'h77, q, w);
    chk("wr_lat_t1_req", 32'(vramReq), 32'd0);
    @(posedge clk); #1;
    chk("wr_lat_t2_req", 32'(vramReq), 32'd1);
    chk("wr_lat_t2_we", 32'(vramWe), 32'd1);
    chk("wr_lat_t2_addr", 32'(vramAddr), 32'hFFFF);
    chk("wr_lat_t2_data", 32'(vramDataOut), 32'h77);
    cpu_op(2'd0, 1'b1, 8'h78, q, w);
    drain;
    chk("wrap_log_size", 32'(wlog.size()), 32'd2);
    for (int i = 0; i < 2 && i < wlog.size(); i++)
      chk($sformatf("wrap_log%0d", i), 32'(wlog[i]), i == 0 ? 32'hFFFF77 : 32'h000078);

    // reset while a write request is outstanding
    gnt_en = 1'b0;
    wlog.delete();
    cpu_op(2'd0, 1'b1, 8'h10, q, w);
    n = 0;
    while (!(vramReq && vramWe) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_req_up", 32'(vramReq && vramWe), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req_drop", 32'(vramReq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    gnt_en = 1'b1;
    repeat (10) @(posedge clk);
    chk("midrst_write_lost", 32'(wlog.size()), 32'd0);
    cpu_op(2'd1, 1'b0, 8'h00, q, w);
    chk("midrst_fifo_empty", 32'(q[6:5]), 32'b01);

    // randomized ops against a plain memory/address model
    drain;
    for (int i = 0; i < 65536; i++) ref_mem[i] = vmem[i];
    gnt_rand = 1'b1;
    cpu_op(2'd3, 1'b1, 8'h20, q, w);
    cpu_op(2'd2, 1'b1, 8'h00, q, w);
    ref_a = 16'h2000;
    ref_p = 1'b0;
    ref_v = 8'h00;
    for (int i = 0; i < 400; i++) begin
      int unsigned k;
      k = $urandom % 8;
      d = 8'($urandom);
      case (k)
        0: begin
          cpu_op(2'd2, 1'b1, d, q, w);
          ref_a[7:0] = d;
        end
        1: begin
          d = 8'h20 + 8'($urandom % 2);
          cpu_op(2'd3, 1'b1, d, q, w);
          ref_a[15:8] = d;
        end
        2, 3: begin
          cpu_op(2'd0, 1'b1, d, q, w);
          ref_mem[ref_a] = d;
          touched.push_back(ref_a);
          ref_a = ref_a + 16'd1;
        end
        4, 5: begin
          cpu_op(2'd0, 1'b0, 8'h00, q, w);
          chk("rand_read", 32'(q), 32'(ref_mem[ref_a]));
          ref_a = ref_a + 16'd1;
        end
        6: begin
          cpu_op(2'd1, 1'b1, d, q, w);
          chk("rand_regWe", 32'(regWe), 32'(ref_p));
          if (ref_p) begin
            chk("rand_regIndex", 32'(regIndex), 32'(d[2:0]));
            chk("rand_regData", 32'(regData), 32'(ref_v));
          end else ref_v = d;
          ref_p = !ref_p;
        end
        default: begin
          logic [1:0] p;
          p = 2'd1 + 2'($urandom % 3);
          cpu_op(p, 1'b0, 8'h00, q, w);
          if (p == 2'd1) begin
            chk("rand_status", 32'(q & 8'h8F), 32'd0);
            ref_p = 1'b0;
          end else chk("rand_p23_read", 32'(q), 32'd0);
        end
      endcase
    end
    gnt_rand = 1'b0;
    drain;
    foreach (touched[i]) chk($sformatf("rand_mem_%04h", touched[i]), 32'(vmem[touched[i]]), 32'(ref_mem[touched[i]]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
